// File: rtl/eci_rx_vc_buffer.sv
// eci_rx_vc_buffer: receive-side VC buffer for the ECI receive path.
// Steers each word of an accepted data block into the FIFO of its VC (idle
// tags >= NUM_VCS are dropped) and returns one credit per consumed word to the
// transmit-link arbiter as round-robin (vc, count) messages.
// Optional feature: define ECI_RX_VC_STATS_EN to add the stat_* counters.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   blk_data/_vc_no       block words and their VC tags (word i in slice i)
//   blk_valid/_ready      block handshake; ready depends on occupancies only
//   vc_data/_valid/_ready per-VC FIFO head word and pop handshake
//   crd_vc/_cnt/_valid    credit message, held while crd_valid & !crd_ready
//   crd_ready             credit message taken
//   crd_overflow          sticky, a pending credit counter saturated
//   stat_words/_idle/_stall  (ECI_RX_VC_STATS_EN only) wrapping statistics
module eci_rx_vc_buffer #(
    parameter int unsigned NUM_WORDS    = 7,
    parameter int unsigned WORD_WIDTH   = 64,
    parameter int unsigned NUM_VCS      = 13,
    parameter int unsigned VC_NO_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CREDIT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0]  blk_data,
    input  logic [NUM_WORDS*VC_NO_WIDTH-1:0] blk_vc_no,
    input  logic                             blk_valid,
    output logic                             blk_ready,
    output logic [NUM_VCS*WORD_WIDTH-1:0]    vc_data,
    output logic [NUM_VCS-1:0]               vc_valid,
    input  logic [NUM_VCS-1:0]               vc_ready,
    output logic [VC_NO_WIDTH-1:0]           crd_vc,
    output logic [CREDIT_WIDTH-1:0]          crd_cnt,
    output logic                             crd_valid,
    input  logic                             crd_ready,
    output logic                             crd_overflow
`ifdef ECI_RX_VC_STATS_EN
    ,
    output logic [NUM_VCS*32-1:0]            stat_words,
    output logic [31:0]                      stat_idle,
    output logic [31:0]                      stat_stall
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam int unsigned IDX_W = VC_NO_WIDTH + 1;

    logic [WORD_WIDTH-1:0]   mem        [NUM_VCS][FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr     [NUM_VCS];
    logic [PTR_W-1:0]        wr_ptr     [NUM_VCS];
    logic [PTR_W-1:0]        rd_ptr_nxt [NUM_VCS];
    logic [PTR_W-1:0]        wr_ptr_nxt [NUM_VCS];
    logic [OCC_W-1:0]        occ        [NUM_VCS];
    logic [CREDIT_WIDTH-1:0] pending    [NUM_VCS];
    logic [CREDIT_WIDTH-1:0] pend_nxt   [NUM_VCS];
    logic [CNT_W-1:0]        wr_cnt     [NUM_VCS];
    logic [VC_NO_WIDTH-1:0]  wr_vc      [NUM_WORDS];
    logic [PTR_W-1:0]        wr_addr    [NUM_WORDS];
    logic [NUM_WORDS-1:0]    wr_en;
    logic [NUM_VCS-1:0]      pop;
    logic                    accept;
    logic [VC_NO_WIDTH-1:0]  rr_ptr;
    logic [VC_NO_WIDTH-1:0]  sel;
    logic [VC_NO_WIDTH-1:0]  rr_nxt;
    logic                    found;
    logic                    issue;
    logic                    ovf_set;
`ifdef ECI_RX_VC_STATS_EN
    logic [CNT_W-1:0]        idle_cnt;
`endif

    // Block acceptance needs room for a full block in every FIFO.
    always_comb begin
        blk_ready = 1'b1;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (occ[v] > OCC_W'(FIFO_DEPTH - NUM_WORDS)) blk_ready = 1'b0;
        end
    end

    assign accept = blk_valid & blk_ready;
    assign pop    = vc_valid & vc_ready;

    // FIFO heads.
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            vc_valid[v] = (occ[v] != '0);
            vc_data[v*WORD_WIDTH +: WORD_WIDTH] = mem[v][rd_ptr[v]];
        end
    end

    // Slot placement: a word lands after the earlier same-VC words of its block.
    always_comb begin
        logic [VC_NO_WIDTH-1:0] t;
        logic [SUM_W-1:0]       sum;
        t     = '0;
        sum   = '0;
        wr_en = '0;
`ifdef ECI_RX_VC_STATS_EN
        idle_cnt = '0;
`endif
        for (int v = 0; v < NUM_VCS; v++) wr_cnt[v] = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            wr_vc[i]   = '0;
            wr_addr[i] = '0;
        end
        for (int i = 0; i < NUM_WORDS; i++) begin
            t        = blk_vc_no[i*VC_NO_WIDTH +: VC_NO_WIDTH];
            wr_vc[i] = t;
            if (accept) begin
                if (32'(t) < NUM_VCS) begin
                    sum = SUM_W'(wr_ptr[t]) + SUM_W'(wr_cnt[t]);
                    if (sum >= SUM_W'(FIFO_DEPTH)) sum = sum - SUM_W'(FIFO_DEPTH);
                    wr_addr[i] = PTR_W'(sum);
                    wr_en[i]   = 1'b1;
                    wr_cnt[t]  = wr_cnt[t] + CNT_W'(1);
                end
`ifdef ECI_RX_VC_STATS_EN
                else begin
                    idle_cnt = idle_cnt + CNT_W'(1);
                end
`endif
            end
        end
    end

    // Pointer advance with explicit wrap so FIFO_DEPTH need not be a power of two.
    always_comb begin
        logic [SUM_W-1:0] sum;
        sum = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            sum = SUM_W'(wr_ptr[v]) + SUM_W'(wr_cnt[v]);
            if (sum >= SUM_W'(FIFO_DEPTH)) sum = sum - SUM_W'(FIFO_DEPTH);
            wr_ptr_nxt[v] = PTR_W'(sum);
            rd_ptr_nxt[v] = rd_ptr[v];
            if (pop[v]) begin
                rd_ptr_nxt[v] = (rd_ptr[v] == PTR_W'(FIFO_DEPTH - 1)) ? '0
                                                                        : rd_ptr[v] + PTR_W'(1);
            end
        end
    end

    // Storage array, no reset needed: contents are only observed while valid.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (wr_en[i] && wr_vc[i] == VC_NO_WIDTH'(v)) begin
                    mem[v][wr_addr[i]] <= blk_data[i*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    // FIFO pointers and occupancies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                occ[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                rd_ptr[v] <= rd_ptr_nxt[v];
                wr_ptr[v] <= wr_ptr_nxt[v];
                occ[v]    <= occ[v] + OCC_W'(wr_cnt[v]) - OCC_W'(pop[v]);
            end
        end
    end

    // Round-robin search for the first VC with pending credit, starting at rr_ptr.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand  = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_VCS; k++) begin
            cand = {1'b0, rr_ptr} + IDX_W'(k);
            if (cand >= IDX_W'(NUM_VCS)) cand = cand - IDX_W'(NUM_VCS);
            if (!found && pending[VC_NO_WIDTH'(cand)] != '0) begin
                found = 1'b1;
                sel   = VC_NO_WIDTH'(cand);
            end
        end
        rr_nxt = (sel == VC_NO_WIDTH'(NUM_VCS - 1)) ? '0 : sel + VC_NO_WIDTH'(1);
    end

    assign issue = ~crd_valid | crd_ready;

    // Pending accrual; the granted VC keeps a pop made in its grant cycle.
    always_comb begin
        ovf_set = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            pend_nxt[v] = pending[v];
            if (issue && found && sel == VC_NO_WIDTH'(v)) begin
                pend_nxt[v] = pop[v] ? CREDIT_WIDTH'(1) : '0;
            end else if (pop[v]) begin
                if (&pending[v]) ovf_set = 1'b1;
                else             pend_nxt[v] = pending[v] + CREDIT_WIDTH'(1);
            end
        end
    end

    // Credit message register and arbitration state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VCS; v++) pending[v] <= '0;
            rr_ptr       <= '0;
            crd_valid    <= 1'b0;
            crd_vc       <= '0;
            crd_cnt      <= '0;
            crd_overflow <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) pending[v] <= pend_nxt[v];
            if (ovf_set) crd_overflow <= 1'b1;
            if (issue) begin
                crd_valid <= found;
                if (found) begin
                    crd_vc  <= sel;
                    crd_cnt <= pending[sel];
                    rr_ptr  <= rr_nxt;
                end
            end
        end
    end

`ifdef ECI_RX_VC_STATS_EN
    // Wrapping statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words <= '0;
            stat_idle  <= '0;
            stat_stall <= '0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                stat_words[v*32 +: 32] <= stat_words[v*32 +: 32] + 32'(wr_cnt[v]);
            end
            stat_idle <= stat_idle + 32'(idle_cnt);
            if (blk_valid && !blk_ready) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eci_rx_vc_buffer.sv
// Self-checking bench for eci_rx_vc_buffer: directed vector table, multi-cycle
// corner sequences and randomized traffic against a queue-based reference model.
module tb_eci_rx_vc_buffer;

    localparam int NW   = 7;
    localparam int WW   = 64;
    localparam int NV   = 13;
    localparam int VW   = 4;
    localparam int FD   = 16;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NW*WW-1:0]  blk_data = '0;
    logic [NW*VW-1:0]  blk_vc_no = '0;
    logic              blk_valid = 1'b0;
    logic              blk_ready;
    logic [NV*WW-1:0]  vc_data;
    logic [NV-1:0]     vc_valid;
    logic [NV-1:0]     vc_ready = '0;
    logic [VW-1:0]     crd_vc;
    logic [CW-1:0]     crd_cnt;
    logic              crd_valid;
    logic              crd_ready = 1'b0;
    logic              crd_overflow;
`ifdef ECI_RX_VC_STATS_EN
    logic [NV*32-1:0]  stat_words;
    logic [31:0]       stat_idle;
    logic [31:0]       stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    eci_rx_vc_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .blk_data     (blk_data),
        .blk_vc_no    (blk_vc_no),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .vc_data      (vc_data),
        .vc_valid     (vc_valid),
        .vc_ready     (vc_ready),
        .crd_vc       (crd_vc),
        .crd_cnt      (crd_cnt),
        .crd_valid    (crd_valid),
        .crd_ready    (crd_ready),
        .crd_overflow (crd_overflow)
`ifdef ECI_RX_VC_STATS_EN
        ,
        .stat_words   (stat_words),
        .stat_idle    (stat_idle),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WW-1:0] mq [NV][$];
    int            pend [NV];
    int            m_rr;
    bit            m_cv;
    int            m_cvc;
    int            m_ccnt;
    bit            m_ovf;
    typedef struct { int vc; int cnt; } msg_t;
    msg_t          msgs[$];
    int            crd_sum [NV];
`ifdef ECI_RX_VC_STATS_EN
    logic [31:0]   m_words [NV];
    logic [31:0]   m_idle;
    logic [31:0]   m_stall;
`endif

    function automatic bit model_ready();
        for (int v = 0; v < NV; v++) if (mq[v].size() > FD - NW) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            pend[v] = 0;
        end
        m_rr = 0; m_cv = 0; m_cvc = 0; m_ccnt = 0; m_ovf = 0;
`ifdef ECI_RX_VC_STATS_EN
        for (int v = 0; v < NV; v++) m_words[v] = '0;
        m_idle = '0; m_stall = '0;
`endif
    endtask

    task automatic compare();
        logic [NV-1:0] ev;
        for (int v = 0; v < NV; v++) ev[v] = (mq[v].size() != 0);
        check("blk_ready", 64'(blk_ready), 64'(model_ready()));
        check("vc_valid", 64'(vc_valid), 64'(ev));
        for (int v = 0; v < NV; v++)
            if (ev[v]) check($sformatf("vc_data%0d", v), vc_data[v*WW +: WW], mq[v][0]);
        check("crd_valid", 64'(crd_valid), 64'(m_cv));
        if (m_cv) begin
            check("crd_vc", 64'(crd_vc), 64'(m_cvc));
            check("crd_cnt", 64'(crd_cnt), 64'(m_ccnt));
        end
        check("crd_overflow", 64'(crd_overflow), 64'(m_ovf));
`ifdef ECI_RX_VC_STATS_EN
        for (int v = 0; v < NV; v++)
            check($sformatf("stat_words%0d", v), 64'(stat_words[v*32 +: 32]), 64'(m_words[v]));
        check("stat_idle", 64'(stat_idle), 64'(m_idle));
        check("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
    endtask

    task automatic model_step();
        bit rdy;
        bit p;
        int g;
        int j;
        int t;
        rdy = model_ready();
        g = -1;
        if (!m_cv || crd_ready) begin
            for (int k = 0; k < NV; k++) begin
                j = (m_rr + k) % NV;
                if (g < 0 && pend[j] > 0) g = j;
            end
            m_cv = (g >= 0);
            if (g >= 0) begin
                m_cvc  = g;
                m_ccnt = pend[g];
                m_rr   = (g + 1) % NV;
            end
        end
        for (int v = 0; v < NV; v++) begin
            p = (mq[v].size() > 0) && vc_ready[v];
            if (v == g) pend[v] = p ? 1 : 0;
            else if (p) begin
                if (pend[v] == CMAX) m_ovf = 1'b1;
                else pend[v]++;
            end
            if (p) void'(mq[v].pop_front());
        end
        if (blk_valid && rdy) begin
            for (int i = 0; i < NW; i++) begin
                t = int'(blk_vc_no[i*VW +: VW]);
                if (t < NV) begin
                    mq[t].push_back(blk_data[i*WW +: WW]);
`ifdef ECI_RX_VC_STATS_EN
                    m_words[t] = m_words[t] + 32'd1;
`endif
                end
`ifdef ECI_RX_VC_STATS_EN
                else m_idle = m_idle + 32'd1;
`endif
            end
        end
`ifdef ECI_RX_VC_STATS_EN
        if (blk_valid && !rdy) m_stall = m_stall + 32'd1;
`endif
    endtask

    // Outputs are compared on the falling edge; the model then advances over the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            check("rst_blk_ready", 64'(blk_ready), 64'd1);
            check("rst_vc_valid", 64'(vc_valid), 64'd0);
            check("rst_crd_valid", 64'(crd_valid), 64'd0);
            check("rst_crd_vc", 64'(crd_vc), 64'd0);
            check("rst_crd_cnt", 64'(crd_cnt), 64'd0);
            check("rst_crd_overflow", 64'(crd_overflow), 64'd0);
        end else begin
            compare();
            if (crd_valid && crd_ready && int'(crd_vc) < NV) begin
                msgs.push_back('{int'(crd_vc), int'(crd_cnt)});
                crd_sum[crd_vc] += int'(crd_cnt);
            end
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_data();
        for (int i = 0; i < NW; i++) blk_data[i*WW +: WW] = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        blk_valid = 1'b0;
        vc_ready  = '0;
        crd_ready = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1);
    endtask

    typedef struct {
        logic [NW-1:0][VW-1:0] tags;
        logic [NV-1:0]         exp_valid;
        int                    exp_words;
    } vec_t;

    vec_t vecs [6];
    int   arb_vc  [4] = '{1, 4, 9, 1};
    int   arb_cnt [4] = '{1, 3, 2, 1};

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int acc;
        int sum;

        // Tags are listed word 6 down to word 0.
        vecs[0] = '{tags: {7{4'd3}}, exp_valid: 13'h0008, exp_words: 7};
        vecs[1] = '{tags: {4'd0, 4'd15, 4'd2, 4'd1, 4'd15, 4'd1, 4'd0}, exp_valid: 13'h0007, exp_words: 5};
        vecs[2] = '{tags: {7{4'd15}}, exp_valid: 13'h0000, exp_words: 0};
        vecs[3] = '{tags: {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, exp_valid: 13'h007F, exp_words: 7};
        vecs[4] = '{tags: {4'd0, 4'd11, 4'd12, 4'd14, 4'd13, 4'd12, 4'd12}, exp_valid: 13'h1801, exp_words: 5};
        vecs[5] = '{tags: {7{4'd12}}, exp_valid: 13'h1000, exp_words: 7};

        do_reset();

        // Single blocks into an empty buffer, then drain.
        for (int k = 0; k < 6; k++) begin
            for (int v = 0; v < NV; v++) crd_sum[v] = 0;
            crd_ready = 1'b1;
            vc_ready  = '0;
            blk_vc_no = vecs[k].tags;
            fill_data();
            blk_valid = 1'b1;
            tick(1);
            blk_valid = 1'b0;
            check($sformatf("vec%0d_valid", k), 64'(vc_valid), 64'(vecs[k].exp_valid));
            vc_ready = '1;
            pops = 0;
            for (int c = 0; c < 10; c++) begin
                pops += $countones(vc_valid & vc_ready);
                tick(1);
            end
            tick(20);
            check($sformatf("vec%0d_pops", k), 64'(pops), 64'(vecs[k].exp_words));
            sum = 0;
            for (int v = 0; v < NV; v++) sum += crd_sum[v];
            check($sformatf("vec%0d_credits", k), 64'(sum), 64'(vecs[k].exp_words));
        end
        check("vc3_credit_sum", 64'(crd_sum[3]), 64'd0);

        // Backpressure on VC 5.
        vc_ready  = '0;
        blk_vc_no = {7{4'd5}};
        blk_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            acc += int'(blk_valid & blk_ready);
            fill_data();
            tick(1);
        end
        blk_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_ready_low", 64'(blk_ready), 64'd0);
        vc_ready = 13'h0020;
        tick(4);
        check("bp_occ10_ready", 64'(blk_ready), 64'd0);
        tick(1);
        check("bp_occ9_ready", 64'(blk_ready), 64'd1);

        // Block write and pop on the same FIFO in one cycle: 9 + 7 - 1 = 15.
        fill_data();
        blk_valid = 1'b1;
        tick(1);
        blk_valid = 1'b0;
        vc_ready  = '0;
        check("wp_ready_low", 64'(blk_ready), 64'd0);
        check("wp_valid5", 64'(vc_valid[5]), 64'd1);
        vc_ready = 13'h0020;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            pops += $countones(vc_valid & vc_ready);
            tick(1);
        end
        check("wp_pops", 64'(pops), 64'd15);
        crd_ready = 1'b1;
        tick(10);

        // Credit arbitration with the first grant held.
        do_reset();
        msgs.delete();
        blk_vc_no = {4'd9, 4'd9, 4'd4, 4'd4, 4'd4, 4'd1, 4'd1};
        fill_data();
        blk_valid = 1'b1;
        tick(1);
        blk_valid = 1'b0;
        vc_ready  = 13'h0212;
        tick(6);
        check("arb_hold_valid", 64'(crd_valid), 64'd1);
        check("arb_hold_vc", 64'(crd_vc), 64'd1);
        check("arb_hold_cnt", 64'(crd_cnt), 64'd1);
        crd_ready = 1'b1;
        tick(10);
        check("arb_msg_count", 64'(msgs.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < msgs.size()) begin
                check($sformatf("arb_msg%0d_vc", i), 64'(msgs[i].vc), 64'(arb_vc[i]));
                check($sformatf("arb_msg%0d_cnt", i), 64'(msgs[i].cnt), 64'(arb_cnt[i]));
            end
        end

        // Pending counter saturation while the credit channel is stalled.
        do_reset();
        vc_ready  = 13'h0001;
        blk_vc_no = {7{4'd0}};
        blk_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            fill_data();
            tick(1);
        end
        check("sat_no_ovf_yet", 64'(crd_overflow), 64'd0);
        for (int c = 0; c < 100; c++) begin
            fill_data();
            tick(1);
        end
        check("sat_ovf", 64'(crd_overflow), 64'd1);
        check("sat_hold_valid", 64'(crd_valid), 64'd1);
        check("sat_hold_cnt", 64'(crd_cnt), 64'd1);
        blk_valid = 1'b0;
        crd_ready = 1'b1;
        tick(40);

        // Randomized traffic with an asynchronous reset in the middle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            blk_valid = 1'($urandom_range(0, 1));
            for (int i = 0; i < NW; i++) blk_vc_no[i*VW +: VW] = VW'($urandom_range(0, 15));
            fill_data();
            vc_ready  = NV'($urandom | $urandom);
            crd_ready = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_vc_valid", 64'(vc_valid), 64'd0);
                check("async_crd_valid", 64'(crd_valid), 64'd0);
                check("async_blk_ready", 64'(blk_ready), 64'd1);
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
            tick(1);
        end
        blk_valid = 1'b0;
        vc_ready  = '1;
        crd_ready = 1'b1;
        tick(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
